// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH-channel PWM generator sharing one free-running period
// counter. Duty values are double-buffered (pending -> active) and only
// reach the comparators at a period boundary, or immediately while the
// block is disabled.
//
// Optional feature: define PWM_PERIOD_EN to take the counter top value from
// the period port (sampled into period_act at each wrap, and every cycle
// while en=0). Without it the counter always runs over the full WIDTH range.
module pwm_multi #(
    parameter int                NUM_CH   = 4,
    parameter int                WIDTH    = 10,
    parameter logic [NUM_CH-1:0] INV_MASK = {NUM_CH{1'b0}},
    localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_duty,
    input  logic [WIDTH-1:0]  period,
    output logic [NUM_CH-1:0] pwm,
    output logic              per_strb
);

    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  top;
    logic              wrap;
    logic              load;
    logic [WIDTH-1:0]  pending     [NUM_CH];
    logic [WIDTH-1:0]  active      [NUM_CH];
    logic [WIDTH-1:0]  pending_nxt [NUM_CH];
    logic [NUM_CH-1:0] raw;

`ifdef PWM_PERIOD_EN
    logic [WIDTH-1:0]  period_act;

    assign top = period_act;
`else
    logic              period_unused;

    assign top           = '1;
    assign period_unused = ^period;
`endif

    // A wrap closes the current period; while disabled, the buffers are
    // transparent so a write is visible as soon as counting starts.
    assign wrap = en && (cnt == top);
    assign load = !en || wrap;

    // Merge this cycle's write into the pending image. Out-of-range channel
    // numbers match no index and are therefore dropped.
    always_comb begin
        // NOTE: every element gets its hold value first, so no path through
        // this block leaves a variable unassigned and no latch is inferred.
        for (int i = 0; i < NUM_CH; i++) begin
            pending_nxt[i] = pending[i];
            if (wr_en && (wr_ch == CH_W'(i))) begin
                pending_nxt[i] = wr_duty;
            end
        end
    end

    // Per-channel comparison against the shared counter, before polarity.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = en && (cnt < active[i]);
        end
    end

    // Period counter: counts 0..top while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every
        // always_ff block samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Duty double-buffer: writes land in pending, active follows on load.
    // A write coinciding with a wrap reaches active through pending_nxt.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these small register arrays are reset explicitly because an
        // unreset duty would drive undefined pulses on the first period.
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pending[i] <= pending_nxt[i];
                if (load) begin
                    active[i] <= pending_nxt[i];
                end
            end
        end
    end

`ifdef PWM_PERIOD_EN
    // Shadow of the period port; all-ones after reset matches fixed mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act <= '1;
        end else if (load) begin
            period_act <= period;
        end
    end
`endif

    // Registered outputs: polarity applied here, idle level while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm      <= INV_MASK;
            per_strb <= 1'b0;
        end else begin
            pwm      <= raw ^ INV_MASK;
            per_strb <= en && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for pwm_multi. A 4-channel instance with
// an inverted channel 2 and a 3-channel instance share all stimulus; both are
// compared every cycle against a behavioural model of the channel rules, and
// scenario tasks measure whole periods (length, active cycles) directly.
module tb_pwm_multi;

    localparam logic [3:0] INV = 4'b0100;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_ch   = 2'd0;
    logic [3:0] wr_duty = 4'd0;
    logic [3:0] period  = 4'hF;
    logic [3:0] pwm;
    logic       per_strb;
    logic [2:0] pwm3;
    logic       per_strb3;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    int         m_cnt;
    int         m_per;
    int         m_pend  [4];
    int         m_act   [4];
    int         m3_pend [3];
    int         m3_act  [3];
    logic [3:0] m_pwm;
    logic [2:0] m3_pwm;
    logic       m_strb;

    always #5 clk = ~clk;

    pwm_multi #(.NUM_CH(4), .WIDTH(4), .INV_MASK(INV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .period(period), .pwm(pwm), .per_strb(per_strb)
    );

    pwm_multi #(.NUM_CH(3), .WIDTH(4), .INV_MASK(3'b000)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_duty(wr_duty), .period(period), .pwm(pwm3), .per_strb(per_strb3)
    );

    task automatic model_reset();
        m_cnt  = 0;
        m_per  = 15;
        m_pwm  = INV;
        m3_pwm = 3'b000;
        m_strb = 1'b0;
        for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_act[i] = 0; end
        for (int i = 0; i < 3; i++) begin m3_pend[i] = 0; m3_act[i] = 0; end
    endtask

    // One clock of the channel rules, using the inputs held across the edge.
    task automatic model_clock();
        int top;
        int idx;
        bit wrap;
        if (!rst_n) begin
            model_reset();
            return;
        end
`ifdef PWM_PERIOD_EN
        top = m_per;
`else
        top = 15;
`endif
        wrap   = en && (m_cnt == top);
        m_strb = en && (m_cnt == 0);
        for (int i = 0; i < 4; i++) m_pwm[i]  = (en && (m_cnt < m_act[i])) ^ INV[i];
        for (int i = 0; i < 3; i++) m3_pwm[i] = en && (m_cnt < m3_act[i]);
        if (wr_en) begin
            idx = int'(wr_ch);
            if (idx < 4) m_pend[idx]  = int'(wr_duty);
            if (idx < 3) m3_pend[idx] = int'(wr_duty);
        end
        if (!en || wrap) begin
            for (int i = 0; i < 4; i++) m_act[i]  = m_pend[i];
            for (int i = 0; i < 3; i++) m3_act[i] = m3_pend[i];
            m_per = int'(period);
        end
        m_cnt = (!en || wrap) ? 0 : m_cnt + 1;
    endtask

    // Advance one clock and compare both instances with the model.
    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        n_cmp++;
        if (pwm !== m_pwm || per_strb !== m_strb || pwm3 !== m3_pwm || per_strb3 !== m_strb) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: pwm=%b strb=%b pwm3=%b strb3=%b, required pwm=%b strb=%b pwm3=%b",
                     $time, pwm, per_strb, pwm3, per_strb3, m_pwm, m_strb, m3_pwm);
        end
    endtask

    task automatic write(input logic [1:0] ch, input logic [3:0] val);
        wr_en = 1'b1; wr_ch = ch; wr_duty = val;
        tick();
        wr_en = 1'b0;
    endtask

    // Measure the period starting at the next strobe (or the current one):
    // its length and the active cycles of channel ch. Optionally writes
    // (wch, wval) on the cycle the counter equals wcnt. len=-1 on timeout.
    task automatic count_period(input int ch, input bit do_wr, input int wcnt,
                                input logic [1:0] wch, input logic [3:0] wval,
                                output int highs, output int len, output bit first);
        int n = 0;
        highs = 0; len = -1; first = 1'b0;
        while (per_strb !== 1'b1 && n < 64) begin tick(); n++; end
        if (per_strb !== 1'b1) return;
        first = pwm[ch] ^ INV[ch];
        highs = first ? 1 : 0;
        len   = 1;
        for (int k = 0; k < 64; k++) begin
            if (do_wr && m_cnt == wcnt) begin wr_en = 1'b1; wr_ch = wch; wr_duty = wval; end
            tick();
            wr_en = 1'b0;
            if (per_strb === 1'b1) return;
            len++;
            if (pwm[ch] ^ INV[ch]) highs++;
        end
        len = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; wr_en = 1'b1; wr_ch = 2'd2; wr_duty = 4'd9;
        repeat (3) tick();
        n_cmp++;
        if (pwm !== INV || per_strb !== 1'b0 || pwm3 !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_outputs: pwm=%b strb=%b pwm3=%b, required pwm=%b strb=0 pwm3=000",
                     pwm, per_strb, pwm3, INV);
        end
        wr_en = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (per_strb !== 1'b1 || pwm !== INV) begin
            n_bad++;
            $display("FAIL reset_release: strb=%b pwm=%b, required strb=1 pwm=%b", per_strb, pwm, INV);
        end
    endtask

    task automatic test_basic();
        int h, l; bit f;
        en = 1'b0;
        write(2'd0, 4'd4);
        tick();
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            count_period(0, 1'b0, 0, 2'd0, 4'd0, h, l, f);
            n_cmp++;
            if (h !== 4 || l !== 16 || f !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_period%0d: high=%0d len=%0d first=%0d, required high=4 len=16 first=1", p, h, l, f);
            end
        end
    endtask

    task automatic test_double_buffer();
        int h, l; bit f;
        write(2'd1, 4'd5);
        count_period(1, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        count_period(1, 1'b1, 7, 2'd1, 4'd10, h, l, f);
        n_cmp++;
        if (h !== 5 || l !== 16) begin
            n_bad++;
            $display("FAIL dbuf_keep_old: high=%0d len=%0d, required high=5 len=16", h, l);
        end
        count_period(1, 1'b1, 15, 2'd1, 4'd3, h, l, f);
        n_cmp++;
        if (h !== 10) begin
            n_bad++;
            $display("FAIL dbuf_new_value: high=%0d, required 10", h);
        end
        count_period(1, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        n_cmp++;
        if (h !== 3) begin
            n_bad++;
            $display("FAIL dbuf_wrap_bypass: high=%0d, required 3", h);
        end
    endtask

    task automatic test_edge_duty();
        int h, l; bit f;
        write(2'd2, 4'd0);
        write(2'd3, 4'd15);
        count_period(2, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        count_period(2, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        n_cmp++;
        if (h !== 0 || l !== 16) begin
            n_bad++;
            $display("FAIL duty_zero: high=%0d len=%0d, required high=0 len=16", h, l);
        end
        count_period(3, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        n_cmp++;
        if (h !== 15 || l !== 16) begin
            n_bad++;
            $display("FAIL duty_max: high=%0d len=%0d, required high=15 len=16", h, l);
        end
        // Channel 3 exists only on the 4-channel instance; the 3-channel one
        // must ignore it (the per-cycle model checks that instance).
        write(2'd3, 4'd9);
        count_period(3, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        count_period(3, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        n_cmp++;
        if (h !== 9) begin
            n_bad++;
            $display("FAIL duty_ch3: high=%0d, required 9", h);
        end
    endtask

    task automatic test_inv_and_enable();
        int h, l; bit f;
        en = 1'b0;
        tick();
        n_cmp++;
        if (pwm !== INV || pwm[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL inv_idle: pwm=%b, required %b", pwm, INV);
        end
        write(2'd2, 4'd6);
        en = 1'b1;
        count_period(2, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        n_cmp++;
        if (h !== 6 || f !== 1'b1 || l !== 16) begin
            n_bad++;
            $display("FAIL inv_active_low: low_cycles=%0d first=%0d len=%0d, required 6 1 16", h, f, l);
        end
        repeat (3) tick();
        en = 1'b0;
        tick();
        n_cmp++;
        if (pwm !== INV || per_strb !== 1'b0) begin
            n_bad++;
            $display("FAIL en_fall: pwm=%b strb=%b, required pwm=%b strb=0", pwm, per_strb, INV);
        end
        en = 1'b1;
        count_period(2, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        n_cmp++;
        if (h !== 6) begin
            n_bad++;
            $display("FAIL pending_retained: low_cycles=%0d, required 6", h);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        write(2'd0, 4'd8);
        while (!(m_cnt == 3 && m_act[0] == 8) && n < 64) begin tick(); n++; end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (pwm !== INV || per_strb !== 1'b0 || pwm3 !== 3'b000) begin
            n_bad++;
            $display("FAIL async_reset: pwm=%b strb=%b pwm3=%b, required pwm=%b strb=0 pwm3=000",
                     pwm, per_strb, pwm3, INV);
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            en      = ($urandom_range(0, 31) != 0);
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_duty = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 40) == 0) period = 4'($urandom_range(0, 15));
            tick();
        end
        wr_en  = 1'b0;
        period = 4'hF;
        en     = 1'b0;
        tick();
    endtask

`ifdef PWM_PERIOD_EN
    task automatic test_period();
        int h, l; bit f;
        en = 1'b0; period = 4'd9;
        write(2'd0, 4'd3);
        en = 1'b1;
        count_period(0, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        n_cmp++;
        if (h !== 3 || l !== 10) begin
            n_bad++;
            $display("FAIL period9_duty3: high=%0d len=%0d, required 3 10", h, l);
        end
        write(2'd0, 4'd12);
        count_period(0, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        count_period(0, 1'b0, 0, 2'd0, 4'd0, h, l, f);
        n_cmp++;
        if (h !== 10 || l !== 10) begin
            n_bad++;
            $display("FAIL period9_duty12: high=%0d len=%0d, required 10 10", h, l);
        end
        period = 4'd0;
        repeat (12) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (per_strb !== 1'b1 || pwm[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL period_zero: strb=%b pwm0=%b, required 1 1", per_strb, pwm[0]);
            end
        end
        en = 1'b0; period = 4'hF;
        tick();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_double_buffer();
        test_edge_duty();
        test_inv_and_enable();
        test_async_reset();
`ifdef PWM_PERIOD_EN
        test_period();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
